// File: rtl/configurable_multiplication.sv
// rtl/configurable_multiplication.sv - iterative shift-add multiplier: 8x8, dual 8x8 lanes, or 16x16
module configurable_multiplication (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] multiplicand_i,
    input  logic [15:0] multiplier_i,
    input  logic        enable_i,
    input  logic [1:0]  cm_i,
    output logic [31:0] product16x16_o,
    output logic        data_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // mcand holds the shifted multiplicand; in dual mode its two halves are
    // independent lanes, each starting as a zero-extended byte.
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] acc;
    logic        dual;
    logic [3:0]  count;

    logic [15:0] addend_lo;
    logic [15:0] addend_hi;
    logic [16:0] sum_lo;
    logic        carry;
    logic [15:0] sum_hi;
    logic [31:0] acc_next;

    // One add step: the low half adds on multiplier bit 0; the high half adds
    // on bit 8 in dual mode (high lane) or bit 0 otherwise. The carry from the
    // low half only crosses into the high half when the lanes are joined.
    always_comb begin
        addend_lo = mplier[0] ? mcand[15:0] : 16'd0;
        if (dual) begin
            addend_hi = mplier[8] ? mcand[31:16] : 16'd0;
        end else begin
            addend_hi = mplier[0] ? mcand[31:16] : 16'd0;
        end
        sum_lo   = {1'b0, acc[15:0]} + {1'b0, addend_lo};
        carry    = dual ? 1'b0 : sum_lo[16];
        sum_hi   = acc[31:16] + addend_hi + {15'd0, carry};
        acc_next = {sum_hi, sum_lo[15:0]};
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the result is presented only while in DONE.
    always_comb begin
        state_next   = state;
        data_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                data_valid_o = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch on start, one shift-add per BUSY cycle, result capture on the last step.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mcand          <= 32'd0;
            mplier         <= 16'd0;
            acc            <= 32'd0;
            dual           <= 1'b0;
            count          <= 4'd0;
            product16x16_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        acc  <= 32'd0;
                        dual <= (cm_i == 2'b01);
                        if (cm_i[1]) begin
                            mcand  <= {16'd0, multiplicand_i};
                            mplier <= multiplier_i;
                            count  <= 4'd15;
                        end else if (cm_i[0]) begin
                            mcand  <= {8'd0, multiplicand_i[15:8], 8'd0, multiplicand_i[7:0]};
                            mplier <= multiplier_i;
                            count  <= 4'd7;
                        end else begin
                            mcand  <= {24'd0, multiplicand_i[7:0]};
                            mplier <= {8'd0, multiplier_i[7:0]};
                            count  <= 4'd7;
                        end
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[30:0], 1'b0};
                    mplier <= {1'b0, mplier[15:1]};
                    count  <= count - 4'd1;
                    if (count == 4'd0) begin
                        product16x16_o <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_configurable_multiplication.sv
// tb/tb_configurable_multiplication.sv - self-checking bench for configurable_multiplication
module tb_configurable_multiplication;

    logic        clk_i;
    logic        reset_i;
    logic [15:0] multiplicand_i;
    logic [15:0] multiplier_i;
    logic        enable_i;
    logic [1:0]  cm_i;
    logic [31:0] product16x16_o;
    logic        data_valid_o;

    int tests;
    int fails;

    configurable_multiplication dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .enable_i       (enable_i),
        .cm_i           (cm_i),
        .product16x16_o (product16x16_o),
        .data_valid_o   (data_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: what the product should be, from plain arithmetic.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] cm);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = 32'(a[7:0]) * 32'(b[7:0]);
        hi = 32'(a[15:8]) * 32'(b[15:8]);
        if (cm == 2'b00) return lo;
        if (cm == 2'b01) return (hi << 16) | lo;
        return 32'(a) * 32'(b);
    endfunction

    function automatic int lat_of(input logic [1:0] cm);
        return cm[1] ? 16 : 8;
    endfunction

    // Start an op, optionally scramble inputs mid-BUSY, check latency, result, pulse width, hold.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] cm,
                          input bit scramble, input string name);
        logic [31:0] exp;
        int          n;
        int          cnt;
        exp = ref_mul(a, b, cm);
        n   = lat_of(cm);
        @(negedge clk_i);
        multiplicand_i = a;
        multiplier_i   = b;
        cm_i           = cm;
        enable_i       = 1'b1;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        cnt = 0;
        while (cnt < 40) begin
            if (scramble && cnt < n - 2) begin
                multiplicand_i = 16'($urandom);
                multiplier_i   = 16'($urandom);
                cm_i           = 2'($urandom);
                enable_i       = 1'($urandom);
            end else begin
                enable_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            cnt++;
            if (data_valid_o) break;
        end
        enable_i = 1'b0;
        tests++;
        if (cnt !== n) begin
            $display("FAIL %s latency: got %0d edges after start, expected %0d", name, cnt, n);
            fails++;
        end
        tests++;
        if (product16x16_o !== exp) begin
            $display("FAIL %s product: got %h expected %h", name, product16x16_o, exp);
            fails++;
        end
        @(posedge clk_i);
        #1;
        tests++;
        if (data_valid_o !== 1'b0 || product16x16_o !== exp) begin
            $display("FAIL %s hold: valid=%b product=%h expected valid=0 product=%h",
                     name, data_valid_o, product16x16_o, exp);
            fails++;
        end
    endtask

    // Count valid pulses over a window; expected to be zero when idle.
    task automatic expect_quiet(input int cycles, input string name);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            #1;
            if (data_valid_o) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            $display("FAIL %s quiet: got %0d valid pulses expected 0", name, pulses);
            fails++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset_i        = 1'b1;
        enable_i       = 1'b1;
        multiplicand_i = 16'h1234;
        multiplier_i   = 16'h5678;
        cm_i           = 2'b10;
        repeat (2) @(posedge clk_i);
        #1;
        tests++;
        if (product16x16_o !== 32'd0 || data_valid_o !== 1'b0) begin
            $display("FAIL reset: product=%h valid=%b expected 0 0", product16x16_o, data_valid_o);
            fails++;
        end
        @(negedge clk_i);
        enable_i = 1'b0;
        reset_i  = 1'b0;
        expect_quiet(20, "reset_idle");
        tests++;
        if (product16x16_o !== 32'd0) begin
            $display("FAIL reset_hold: product=%h expected 0", product16x16_o);
            fails++;
        end
    endtask

    task automatic test_directed();
        run_op(16'h9B4B, 16'hD1B9, 2'b01, 1'b0, "dual");
        run_op(16'h9B4B, 16'hD1B9, 2'b10, 1'b0, "wide10");
        run_op(16'h9B4B, 16'hD1B9, 2'b11, 1'b0, "wide11");
        run_op(16'h9B4B, 16'hD1B9, 2'b00, 1'b0, "single");
        tests++;
        if (product16x16_o !== 32'h00003633) begin
            $display("FAIL single_const: got %h expected 00003633", product16x16_o);
            fails++;
        end
    endtask

    task automatic test_boundaries();
        run_op(16'hFFFF, 16'hFFFF, 2'b10, 1'b0, "max_wide");
        tests++;
        if (product16x16_o !== 32'hFFFE0001) begin
            $display("FAIL max_wide_const: got %h expected FFFE0001", product16x16_o);
            fails++;
        end
        run_op(16'hFFFF, 16'hFFFF, 2'b01, 1'b0, "max_dual");
        tests++;
        if (product16x16_o !== 32'hFE01FE01) begin
            $display("FAIL max_dual_const: got %h expected FE01FE01", product16x16_o);
            fails++;
        end
        run_op(16'h0000, 16'hBEEF, 2'b10, 1'b0, "zero_wide");
        run_op(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, "max_single");
        run_op(16'hABCD, 16'h0000, 2'b01, 1'b0, "zero_dual");
    endtask

    task automatic test_scramble();
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 2'(i % 4), 1'b1, "scramble");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(16'($urandom), 16'($urandom), 2'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  cm;
        int          gap;
        int          prev;
        int          t;
        int          seen;
        for (int k = 0; k < 2; k++) begin
            a    = 16'($urandom);
            b    = 16'($urandom);
            cm   = (k == 0) ? 2'b01 : 2'b10;
            prev = -1;
            seen = 0;
            @(negedge clk_i);
            multiplicand_i = a;
            multiplier_i   = b;
            cm_i           = cm;
            enable_i       = 1'b1;
            t = 0;
            while (seen < 3 && t < 100) begin
                @(posedge clk_i);
                #1;
                t++;
                if (data_valid_o) begin
                    tests++;
                    if (product16x16_o !== ref_mul(a, b, cm)) begin
                        $display("FAIL b2b product: got %h expected %h",
                                 product16x16_o, ref_mul(a, b, cm));
                        fails++;
                    end
                    if (prev >= 0) begin
                        gap = t - prev;
                        tests++;
                        if (gap != lat_of(cm) + 2) begin
                            $display("FAIL b2b spacing: got %0d expected %0d", gap, lat_of(cm) + 2);
                            fails++;
                        end
                    end
                    prev = t;
                    seen++;
                end
            end
            tests++;
            if (seen != 3) begin
                $display("FAIL b2b pulses: got %0d expected 3", seen);
                fails++;
            end
            enable_i = 1'b0;
            repeat (lat_of(cm) + 4) @(posedge clk_i);
        end
    endtask

    task automatic test_reset_mid_busy();
        run_op(16'h1357, 16'h2468, 2'b10, 1'b0, "pre_abort");
        @(negedge clk_i);
        multiplicand_i = 16'hCAFE;
        multiplier_i   = 16'hF00D;
        cm_i           = 2'b10;
        enable_i       = 1'b1;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        tests++;
        if (product16x16_o !== 32'd0 || data_valid_o !== 1'b0) begin
            $display("FAIL abort: product=%h valid=%b expected 0 0", product16x16_o, data_valid_o);
            fails++;
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        expect_quiet(25, "abort_quiet");
        run_op(16'hCAFE, 16'hF00D, 2'b10, 1'b0, "restart");
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset_i        = 1'b1;
        enable_i       = 1'b0;
        multiplicand_i = 16'd0;
        multiplier_i   = 16'd0;
        cm_i           = 2'b00;
        test_reset();
        test_directed();
        test_boundaries();
        test_scramble();
        test_random();
        test_back_to_back();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
